instr_sequencer: RTL
====================

# instr_sequencer

Fetch/issue controller in front of the instruction decoder. It fetches 32-bit instruction words from instruction memory, classifies each word as one long instruction (movl/movh, bit 31 set) or two packed short instructions, and issues them to the decoder one at a time via `dec_en`/`instr_choose`. It waits for execute completion between issues and applies PC redirects from jumps. It owns the program counter.

## Interface
- `WIDTH`, 32, instruction word width
- `ADDR_WIDTH`, 16, word-address width of instruction memory / PC
- `PC_RESET`, 0, PC value after reset
- `clk`  in  1  clock, all state on rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `imem_req`  out  1  fetch request, held until accepted
- `imem_addr`  out  ADDR_WIDTH  fetch word address (= `pc`)
- `imem_ready`  in  1  fetch accepted, `imem_rdata` valid this cycle
- `imem_rdata`  in  WIDTH  fetched word
- `instr_word`  out  WIDTH  latched word, drives decoder `long_instr`
- `instr_choose`  out  1  0 = upper half [31:16], 1 = lower half [15:0]
- `dec_en`  out  1  one-cycle decode strobe
- `exec_done`  in  1  current instruction retired
- `redirect_valid`  in  1  taken jump, qualified by `exec_done`
- `redirect_addr`  in  ADDR_WIDTH  jump target word address
- `halt`  in  1  stop fetching at next word boundary
- `pc`  out  ADDR_WIDTH  current word PC
- `busy`  out  1  high in every state except RESET_WAIT and HALTED

## Operation
- States: RESET_WAIT, FETCH, ISSUE_HI, EXEC_HI, ISSUE_LO, EXEC_LO, HALTED.
- RESET_WAIT: entered on reset; unconditionally goes to FETCH next cycle.
- FETCH: if `halt`, go to HALTED without requesting. Otherwise `imem_req`=1 and `imem_addr`=`pc`. On `imem_ready`, latch `imem_rdata` into `instr_word` and go to ISSUE_HI.
- ISSUE_HI: `dec_en`=1, `instr_choose`=0 for exactly one cycle, then EXEC_HI.
- EXEC_HI: wait for `exec_done`.
  - With `redirect_valid`: `pc`<=`redirect_addr`, go to FETCH. The lower half is discarded.
  - Otherwise, if `instr_word[31]`=1 (long): `pc`<=`pc`+1, go to FETCH.
  - Otherwise go to ISSUE_LO.
- ISSUE_LO: `dec_en`=1, `instr_choose`=1, one cycle, then EXEC_LO.
- EXEC_LO: wait for `exec_done`. Redirect loads `redirect_addr`; otherwise `pc`<=`pc`+1. Then go to FETCH.
- HALTED: all strobes 0. When `halt` deasserts, go to FETCH with `pc` unchanged.
- `halt` is sampled only in FETCH. It never aborts an in-flight fetch or an unretired instruction.
- `redirect_valid` is ignored when `exec_done`=0 and in every non-EXEC state.
- Encoding rule: a short instruction placed in the upper half must have bit 15 = 0; otherwise the word is treated as long.
- PC arithmetic is modulo 2^ADDR_WIDTH: 0xFFFF+1 wraps to 0x0000 at default width.
- `instr_choose` holds its value outside the ISSUE states (the decoder ignores it without `dec_en`).

## Timing
- Reset values: state RESET_WAIT, `pc`=PC_RESET, `instr_word`=0, `imem_req`=0, `dec_en`=0, `instr_choose`=0, `busy`=0.
- Reset mid-operation is asynchronous and immediate. Any pending fetch is dropped; the memory must tolerate `imem_req` falling without `imem_ready`.
- `imem_req`, `imem_addr`, `dec_en`, `instr_choose` and `busy` are decoded from the registered state, with no combinational path from inputs.
- Fetch handshake: zero-wait memory (`imem_ready` in the same cycle as `imem_req`) costs one cycle. Each wait cycle adds one cycle. `imem_addr` is stable while `imem_req`=1.
- The decoder registers on the edge ending ISSUE, so the earliest legal `exec_done` is the first EXEC cycle.
- Minimum cycles per word: long = 3 (FETCH, ISSUE_HI, EXEC_HI); short pair = 5.
- An `exec_done` pulse is consumed once. A sustained `exec_done` does not skip an ISSUE state.

## Structure
- Shared package `instr_seq_pkg`:
  - state encoding localparams (3-bit);
  - half-select constants `HALF_HI`=0, `HALF_LO`=1;
  - `LONG_BIT`=WIDTH-1.
- Single module, no sub-module: one state register, plus the `pc` and `instr_word` registers with next-value logic.
- Top level instantiates it next to `instr_decoder`:
  - `instr_word` drives `long_instr`;
  - `dec_en` drives `en`;
  - `instr_choose` connects directly.

## Test plan
- Reset release, zero-wait memory, word 0x80001A00 at address 0 (long), `exec_done` in the first EXEC cycle -> `dec_en` pulses once with `instr_choose`=0; `pc`=1 and `imem_req`=1 on the 4th cycle after RESET_WAIT.
- Word 0x40C54011 (two shorts), 2 wait states on fetch -> two `dec_en` pulses: the first with `instr_choose`=0, the second with 1; `pc` 0->1 after the 2nd retire; 7 cycles per word.
- Short pair with a redirect to 0x0040 on the first retire -> no ISSUE_LO; next `imem_addr`=0x0040.
- Redirect to 0x0010 on the lower-half retire -> next fetch at 0x0010, not `pc`+1.
- `halt` asserted during EXEC_LO, released 5 cycles later -> the current instruction retires and the state is HALTED with `busy`=0; no `imem_req` while halted; the fetch then resumes at the incremented `pc`.
- `pc`=0xFFFF with a long word -> next fetch at 0x0000. Assert `reset_n`=0 during a stalled FETCH -> `imem_req`=0 immediately and `pc`=PC_RESET.

Source files
------------

// File: rtl/instr_seq_pkg.sv
// Shared constants for the instruction fetch/issue sequencer: state encoding,
// half-select values and the long-instruction flag position.
package instr_seq_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int LONG_BIT   = WORD_WIDTH - 1;

    localparam logic HALF_HI = 1'b0;
    localparam logic HALF_LO = 1'b1;

    localparam logic [2:0] ST_RESET_WAIT = 3'd0;
    localparam logic [2:0] ST_FETCH      = 3'd1;
    localparam logic [2:0] ST_ISSUE_HI   = 3'd2;
    localparam logic [2:0] ST_EXEC_HI    = 3'd3;
    localparam logic [2:0] ST_ISSUE_LO   = 3'd4;
    localparam logic [2:0] ST_EXEC_LO    = 3'd5;
    localparam logic [2:0] ST_HALTED     = 3'd6;

endpackage

// File: rtl/instr_sequencer.sv
// Fetch/issue controller: fetches instruction words, issues one long or two
// short instructions to the decoder, waits for retirement and applies jumps.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int                    WIDTH      = WORD_WIDTH,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] PC_RESET   = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [WIDTH-1:0]      imem_rdata,
    output logic [WIDTH-1:0]      instr_word,
    output logic                  instr_choose,
    output logic                  dec_en,
    input  logic                  exec_done,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    input  logic                  halt,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy
);

    logic [2:0]            state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc_nxt;
    logic [WIDTH-1:0]      word_nxt;
    logic                  choose_nxt;
    // Set once a fetch has waited a cycle; halt may no longer cancel it.
    logic                  fetch_pending, fetch_pending_nxt;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt         = state;
        pc_nxt            = pc;
        word_nxt          = instr_word;
        choose_nxt        = instr_choose;
        fetch_pending_nxt = 1'b0;
        case (state)
            ST_RESET_WAIT: state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (halt && !fetch_pending) begin
                    state_nxt = ST_HALTED;
                end else if (imem_ready) begin
                    word_nxt   = imem_rdata;
                    choose_nxt = HALF_HI;
                    state_nxt  = ST_ISSUE_HI;
                end else begin
                    fetch_pending_nxt = 1'b1;
                end
            end
            ST_ISSUE_HI: state_nxt = ST_EXEC_HI;
            ST_EXEC_HI: begin
                if (exec_done) begin
                    if (redirect_valid) begin
                        pc_nxt    = redirect_addr;
                        state_nxt = ST_FETCH;
                    end else if (instr_word[WIDTH-1]) begin
                        pc_nxt    = pc + ADDR_WIDTH'(1);
                        state_nxt = ST_FETCH;
                    end else begin
                        choose_nxt = HALF_LO;
                        state_nxt  = ST_ISSUE_LO;
                    end
                end
            end
            ST_ISSUE_LO: state_nxt = ST_EXEC_LO;
            ST_EXEC_LO: begin
                if (exec_done) begin
                    pc_nxt    = redirect_valid ? redirect_addr : pc + ADDR_WIDTH'(1);
                    state_nxt = ST_FETCH;
                end
            end
            ST_HALTED: if (!halt) state_nxt = ST_FETCH;
            default:   state_nxt = ST_RESET_WAIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_RESET_WAIT;
            pc            <= PC_RESET;
            instr_word    <= '0;
            instr_choose  <= HALF_HI;
            fetch_pending <= 1'b0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            instr_word    <= word_nxt;
            instr_choose  <= choose_nxt;
            fetch_pending <= fetch_pending_nxt;
        end
    end

    // Strobes depend on registered state only, never on inputs.
    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = pc;
    assign dec_en    = (state == ST_ISSUE_HI) || (state == ST_ISSUE_LO);
    assign busy      = (state != ST_RESET_WAIT) && (state != ST_HALTED);

endmodule
